rf_wb_arbiter: RTL and testbench

Shares the single write port of the integer register file between two writeback sources, the EXU (ALU/CSR results) and the LSU (load data), using round-robin arbitration. It also keeps a per-register pending-write scoreboard that tells decode when a source operand is not yet valid. It sits between the EXU/LSU writeback outputs and the register file write port (wen/rd/dataD). Decode/issue queries it in parallel with the register file read.

---
 rtl/rf_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package rf_pkg;

  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ZERO_IDX   = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter with a 1-bit priority pointer and one-hot grant.
// Bit 0 of the request/grant vectors is the EXU, bit 1 the LSU.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  wb_src_e r_ptr;

  // A lone request always wins; the pointer only breaks ties.
  assign o_gnt[0] = i_req[0] && (!i_req[1] || (r_ptr == WB_EXU));
  assign o_gnt[1] = i_req[1] && (!i_req[0] || (r_ptr == WB_LSU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= WB_EXU;
    end else if (o_gnt[0]) begin
      r_ptr <= WB_LSU;
    end else if (o_gnt[1]) begin
      r_ptr <= WB_EXU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (EXU vs LSU) with a pending-write scoreboard.
// Optional feature macro RF_WB_BYPASS_EN adds output-stage forwarding ports.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
`ifdef RF_WB_BYPASS_EN
  output logic                  fwd1_valid,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic                  fwd2_valid,
  output logic [DATA_WIDTH-1:0] fwd2_data,
`endif
  output logic                  hazard1,
  output logic                  hazard2
);

  localparam int                    NREG    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_RD = ADDR_WIDTH'(RF_ZERO_IDX);

  logic [1:0]            w_gnt;
  logic                  w_wb_any;
  logic [ADDR_WIDTH-1:0] w_wb_rd;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic                  w_issue_fire;
  logic [NREG-1:0]       w_pending_nxt;

  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NREG-1:0]       r_pending;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req ({lsu_valid, exu_valid}),
    .o_gnt (w_gnt)
  );

  assign exu_ready = w_gnt[0];
  assign lsu_ready = w_gnt[1];
  assign w_wb_any  = |w_gnt;
  assign w_wb_rd   = w_gnt[1] ? lsu_rd   : exu_rd;
  assign w_wb_data = w_gnt[1] ? lsu_data : exu_data;

  // Output stage: the register file always accepts, so this never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_wen <= w_wb_any && (w_wb_rd != ZERO_RD);
      if (w_wb_any) begin
        r_rd   <= w_wb_rd;
        r_data <= w_wb_data;
      end
    end
  end

  assign rf_wen   = r_wen;
  assign rf_rd    = r_rd;
  assign rf_dataD = r_data;

  // One write per register in flight: a second issue to a pending rd waits.
  assign issue_ready  = !r_pending[issue_rd] || (issue_rd == ZERO_RD);
  assign w_issue_fire = issue_valid && issue_ready && (issue_rd != ZERO_RD);

  // Set is applied after clear so a same-cycle issue to the same rd wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_wb_any) begin
      w_pending_nxt[w_wb_rd] = 1'b0;
    end
    if (w_issue_fire) begin
      w_pending_nxt[issue_rd] = 1'b1;
    end
    w_pending_nxt[RF_ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign fwd1_valid = r_wen && (r_rd == rs1);
  assign fwd1_data  = r_data;
  assign fwd2_valid = r_wen && (r_rd == rs2);
  assign fwd2_data  = r_data;
  assign hazard1    = (rs1 != ZERO_RD) && r_pending[rs1];
  assign hazard2    = (rs2 != ZERO_RD) && r_pending[rs2];
`else
  // Data in the output stage is not yet in the register file array.
  assign hazard1 = (rs1 != ZERO_RD) && (r_pending[rs1] || (r_wen && (r_rd == rs1)));
  assign hazard2 = (rs2 != ZERO_RD) && (r_pending[rs2] || (r_wen && (r_rd == rs2)));
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model (honours RF_WB_BYPASS_EN).
module tb_rf_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0] exu_rd, lsu_rd, rf_rd, issue_rd, rs1, rs2;
  logic [DW-1:0] exu_data, lsu_data, rf_dataD;
  logic          rf_wen, issue_valid, issue_ready, hazard1, hazard2;
`ifdef RF_WB_BYPASS_EN
  logic          fwd1_valid, fwd2_valid;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2),
`ifdef RF_WB_BYPASS_EN
    .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
    .hazard1(hazard1), .hazard2(hazard2)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit            pend [32];
  bit            last_lsu;
  bit            m_wen;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 1'b0;
    last_lsu = 1'b1;
    m_wen    = 1'b0;
    m_rd     = '0;
    m_data   = '0;
  endtask

  // When both want the port, the source not served most recently wins.
  function automatic bit exp_ge();
    return exu_valid && (!lsu_valid || last_lsu);
  endfunction
  function automatic bit exp_gl();
    return lsu_valid && (!exu_valid || !last_lsu);
  endfunction
  function automatic bit exp_ir();
    return (issue_rd == 0) || !pend[issue_rd];
  endfunction
  function automatic bit exp_hz(input logic [AW-1:0] rs);
    return (rs != 0) && (pend[rs] || (!BYP && m_wen && (m_rd == rs)));
  endfunction

  task automatic compare_all();
    chk("exu_ready", exu_ready, exp_ge());
    chk("lsu_ready", lsu_ready, exp_gl());
    chk("issue_ready", issue_ready, exp_ir());
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_dataD", rf_dataD, m_data);
    chk("hazard1", hazard1, exp_hz(rs1));
    chk("hazard2", hazard2, exp_hz(rs2));
`ifdef RF_WB_BYPASS_EN
    chk("fwd1_valid", fwd1_valid, m_wen && (m_rd == rs1));
    chk("fwd2_valid", fwd2_valid, m_wen && (m_rd == rs2));
    if (m_wen) begin
      chk("fwd1_data", fwd1_data, m_data);
      chk("fwd2_data", fwd2_data, m_data);
    end
`endif
  endtask

  task automatic model_update();
    bit            ge, gl, ir;
    logic [AW-1:0] rd;
    if (!rst_n) begin
      model_reset();
    end else begin
      ge = exp_ge();
      gl = exp_gl();
      ir = exp_ir();
      if (ge || gl) begin
        rd       = gl ? lsu_rd : exu_rd;
        m_data   = gl ? lsu_data : exu_data;
        m_rd     = rd;
        m_wen    = (rd != 0);
        last_lsu = gl;
        pend[rd] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (issue_valid && ir && issue_rd != 0) pend[issue_rd] = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    exu_valid = 0; lsu_valid = 0; issue_valid = 0;
  endtask

  initial begin
    rst_n = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    model_reset();
    @(posedge clk); #1;
    settle();
    chk("reset_rf_wen", rf_wen, 1'b0);
    chk("reset_issue_ready", issue_ready, 1'b1);
    adv();
    rst_n = 1;

    // EXU alone, plus an issue that marks x9 pending
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    issue_valid = 1; issue_rd = 9; rs1 = 9; rs2 = 5;
    settle();
    chk("exu_only_ready", exu_ready, 1'b1);
    chk("exu_only_hz1_pre", hazard1, 1'b0);
    adv();
    idle_inputs();
    settle();
    chk("exu_only_wen", rf_wen, 1'b1);
    chk("exu_only_rd", rf_rd, 5);
    chk("exu_only_data", rf_dataD, 32'hDEADBEEF);
    chk("issue9_hz1", hazard1, 1'b1);
    adv();

    // Asynchronous reset mid-stream, both sources requesting
    exu_valid = 1; exu_rd = 1; exu_data = 32'h1111;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h2222;
    #2 rst_n = 0;
    #1;
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_dataD", rf_dataD, 0);
    chk("rst_hz1", hazard1, 1'b0);
    chk("rst_exu_ready", exu_ready, 1'b1);
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    model_reset();
    adv();
    rst_n = 1;

    // Strict alternation with both sources valid
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_exu_ready", exu_ready, (i % 2) == 0);
      chk("rr_lsu_ready", lsu_ready, (i % 2) == 1);
      adv();
    end
    idle_inputs();

    // WAW stall on x7 until the LSU writes it back
    issue_valid = 1; issue_rd = 7; rs1 = 7; rs2 = 0;
    settle();
    chk("iss7_ready_first", issue_ready, 1'b1);
    adv();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("iss7_ready_second", issue_ready, 1'b0);
      chk("iss7_hz1", hazard1, 1'b1);
      adv();
    end
    issue_valid = 0;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_0077;
    settle();
    chk("lsu7_ready", lsu_ready, 1'b1);
    chk("lsu7_hz1_grant", hazard1, 1'b1);
    adv();
    lsu_valid = 0;
    settle();
    chk("lsu7_wen", rf_wen, 1'b1);
    chk("lsu7_hz1_after", hazard1, BYP ? 1'b0 : 1'b1);
`ifdef RF_WB_BYPASS_EN
    chk("lsu7_fwd1_valid", fwd1_valid, 1'b1);
    chk("lsu7_fwd1_data", fwd1_data, 32'h77);
`endif
    adv();
    settle();
    chk("lsu7_hz1_clear", hazard1, 1'b0);
    adv();

    // Writeback to x0 handshakes but never writes
    exu_valid = 1; exu_rd = 0; exu_data = 32'h1234; rs1 = 0;
    settle();
    chk("x0_ready", exu_ready, 1'b1);
    chk("x0_hz1", hazard1, 1'b0);
    adv();
    exu_valid = 0;
    settle();
    chk("x0_wen", rf_wen, 1'b0);
    chk("x0_hz1_after", hazard1, 1'b0);
    adv();

    // Same-cycle set and clear of x3: the set wins
    issue_valid = 1; issue_rd = 3; exu_valid = 1; exu_rd = 3; exu_data = 32'h3333; rs2 = 3;
    settle();
    chk("sc3_issue_ready", issue_ready, 1'b1);
    chk("sc3_exu_ready", exu_ready, 1'b1);
    adv();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("sc3_hz2", hazard2, 1'b1);
      adv();
    end

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 2000; n++) begin
      exu_valid   = ($urandom_range(0, 99) < 60);
      lsu_valid   = ($urandom_range(0, 99) < 60);
      exu_rd      = AW'($urandom_range(0, 7));
      lsu_rd      = AW'($urandom_range(0, 7));
      exu_data    = $urandom;
      lsu_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_rd    = AW'($urandom_range(0, 7));
      rs1         = AW'($urandom_range(0, 7));
      rs2         = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        #1;
        model_reset();
      end else begin
        rst_n = 1;
      end
      settle();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
